// File: rtl/round_timer_ctrl.sv
// Round sequencer: IDLE -> PRESTART -> PLAY -> OVER, driven by a synchronized 1 Hz seconds count.
// Define ROUND_PAUSE_EN to add the pause/paused ports.
module round_timer_ctrl #(
    parameter int SEC_W         = 6,
    parameter int PRESTART_SECS = 3,
    parameter int ROUND_SECS    = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef ROUND_PAUSE_EN
    input  logic             pause,
    output logic             paused,
`endif
    input  logic [SEC_W-1:0] sec_in,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic [SEC_W-1:0] time_left,
    output logic [1:0]       state,
    output logic             playing,
    output logic             game_over,
    output logic             sec_tick
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESTART = 2'd1;
    localparam logic [1:0] S_PLAY     = 2'd2;
    localparam logic [1:0] S_OVER     = 2'd3;

    localparam logic [SEC_W:0]   PRE_LIM = (SEC_W+1)'(PRESTART_SECS);
    localparam logic [SEC_W:0]   END_LIM = (SEC_W+1)'(PRESTART_SECS + ROUND_SECS);
    localparam logic [SEC_W-1:0] RND_TL  = SEC_W'(ROUND_SECS);

    if (PRESTART_SECS + ROUND_SECS > (2**SEC_W) - 1) begin : g_bad_params
        $error("PRESTART_SECS+ROUND_SECS exceeds the sec_in range");
    end

    logic [SEC_W-1:0] s1_q, s2_q, s2p_q, sec_q;
    logic             sec_tick_q, sec_tick_d;
    logic [1:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic             enable_q, enable_d, clear_q, clear_d;
    logic             playing_q, playing_d, over_q, over_d;
    logic [SEC_W-1:0] tl_q, tl_d;
    logic             paused_q, paused_d;
    logic             hold;
    logic [SEC_W:0]   pre_diff, play_diff, sec_ext;

    // The 2-cycle stability filter rejects sec_in samples caught mid-ripple.
    logic sec_load;
    assign sec_load   = (s2_q == s2p_q);
    assign sec_tick_d = sec_load && (s2_q != sec_q);

    assign sec_ext   = {1'b0, sec_q};
    assign pre_diff  = PRE_LIM - sec_ext;
    assign play_diff = END_LIM - sec_ext;

`ifdef ROUND_PAUSE_EN
    assign hold = pause && !abort && (state_q == S_PRESTART || state_q == S_PLAY);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        enable_d  = 1'b0;
        clear_d   = 1'b0;
        playing_d = 1'b0;
        over_d    = 1'b0;
        paused_d  = 1'b0;
        tl_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (start) pend_d = 1'b1;
                if (pend_q && sec_q == '0) begin
                    state_d = S_PRESTART;
                    pend_d  = 1'b0;
                end
            end
            S_PRESTART: if (sec_ext >= PRE_LIM) state_d = S_PLAY;
            S_PLAY:     if (sec_ext >= END_LIM) state_d = S_OVER;
            default: if (start) begin
                state_d = S_IDLE;
                pend_d  = 1'b1;
            end
        endcase
        if (hold) state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
        end
        case (state_d)
            S_IDLE: begin
                clear_d = 1'b1;
                tl_d    = RND_TL;
            end
            S_PRESTART: begin
                enable_d = 1'b1;
                tl_d     = pre_diff[SEC_W] ? '0 : pre_diff[SEC_W-1:0];
            end
            S_PLAY: begin
                enable_d  = 1'b1;
                playing_d = 1'b1;
                tl_d      = play_diff[SEC_W] ? '0 : play_diff[SEC_W-1:0];
            end
            default: over_d = 1'b1;
        endcase
        if (hold) begin
            enable_d = 1'b0;
            paused_d = 1'b1;
            tl_d     = tl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s2p_q      <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            enable_q   <= 1'b0;
            clear_q    <= 1'b1;
            playing_q  <= 1'b0;
            over_q     <= 1'b0;
            paused_q   <= 1'b0;
            tl_q       <= RND_TL;
        end else begin
            s1_q       <= sec_in;
            s2_q       <= s1_q;
            s2p_q      <= s2_q;
            if (sec_load) sec_q <= s2_q;
            sec_tick_q <= sec_tick_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            clear_q    <= clear_d;
            playing_q  <= playing_d;
            over_q     <= over_d;
            paused_q   <= paused_d;
            tl_q       <= tl_d;
        end
    end

    assign cnt_enable = enable_q;
    assign cnt_clear  = clear_q;
    assign time_left  = tl_q;
    assign state      = state_q;
    assign playing    = playing_q;
    assign game_over  = over_q;
    assign sec_tick   = sec_tick_q;
`ifdef ROUND_PAUSE_EN
    assign paused     = paused_q;
`else
    logic unused_paused;
    assign unused_paused = paused_q;
`endif
endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with hand-computed expectations; pause steps need ROUND_PAUSE_EN.
module tb_round_timer_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [5:0] sec_in;
    logic       cnt_enable, cnt_clear, playing, game_over, sec_tick;
    logic [5:0] time_left;
    logic [1:0] state;
`ifdef ROUND_PAUSE_EN
    logic       pause, paused;
`endif
    int tests = 0;
    int fails = 0;
    int nt;

    round_timer_ctrl #(.SEC_W(6), .PRESTART_SECS(3), .ROUND_SECS(30)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef ROUND_PAUSE_EN
        .pause(pause), .paused(paused),
`endif
        .sec_in(sec_in), .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
        .time_left(time_left), .state(state), .playing(playing),
        .game_over(game_over), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply a new seconds value, wait for the filter + output register, count sec_tick pulses.
    task automatic set_sec(input int v, output int n);
        sec_in = 6'(v);
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (sec_tick) n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sec_in = '0;
`ifdef ROUND_PAUSE_EN
        pause = 1'b0;
`endif
        tick(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_clear", 32'(cnt_clear), 1);
        chk("rst_enable", 32'(cnt_enable), 0);
        chk("rst_tl", 32'(time_left), 30);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_tick", 32'(sec_tick), 0);
        rst_n = 1'b1;
        tick(5);
        chk("idle_hold", 32'(state), 0);

        start = 1'b1; tick(1); start = 1'b0; tick(1);
        chk("pre_state", 32'(state), 1);
        chk("pre_enable", 32'(cnt_enable), 1);
        chk("pre_clear", 32'(cnt_clear), 0);
        chk("pre_tl0", 32'(time_left), 3);

        set_sec(1, nt); chk("pre_tl1", 32'(time_left), 2); chk("tick1", 32'(nt), 1);
        set_sec(2, nt); chk("pre_tl2", 32'(time_left), 1); chk("tick2", 32'(nt), 1);
        set_sec(3, nt);
        chk("play_state", 32'(state), 2);
        chk("play_tl", 32'(time_left), 30);
        chk("play_flag", 32'(playing), 1);
        chk("tick3", 32'(nt), 1);
        set_sec(4, nt); chk("tl4", 32'(time_left), 29);
        set_sec(5, nt); chk("tl5", 32'(time_left), 28);

        sec_in = 6'd9; tick(1);
        set_sec(5, nt);
        chk("glitch_tick", 32'(nt), 0);
        chk("glitch_tl", 32'(time_left), 28);

        for (int v = 6; v <= 32; v++) begin
            set_sec(v, nt);
            chk($sformatf("tl%0d", v), 32'(time_left), 32'(33 - v));
        end
        chk("tick_once", 32'(nt), 1);
        set_sec(33, nt);
        chk("over_state", 32'(state), 3);
        chk("over_tl", 32'(time_left), 0);
        chk("over_flag", 32'(game_over), 1);
        chk("over_enable", 32'(cnt_enable), 0);
        chk("over_clear", 32'(cnt_clear), 0);
        chk("over_playing", 32'(playing), 0);

        start = 1'b1; tick(1); start = 1'b0;
        chk("restart_idle", 32'(state), 0);
        chk("restart_clear", 32'(cnt_clear), 1);
        chk("restart_tl", 32'(time_left), 30);
        tick(4);
        chk("restart_wait", 32'(state), 0);
        set_sec(0, nt);
        chk("auto_pre", 32'(state), 1);
        chk("auto_enable", 32'(cnt_enable), 1);

        // Jump past the prestart threshold straight into PLAY.
        set_sec(12, nt);
        chk("jump_state", 32'(state), 2);
        chk("jump_tl", 32'(time_left), 21);

        abort = 1'b1; start = 1'b1; tick(1); abort = 1'b0; start = 1'b0;
        chk("abort_state", 32'(state), 0);
        chk("abort_clear", 32'(cnt_clear), 1);
        set_sec(0, nt); tick(2);
        chk("abort_nopend", 32'(state), 0);
        set_sec(12, nt);
        start = 1'b1; tick(1); start = 1'b0; tick(5);
        chk("pend_wait", 32'(state), 0);
        set_sec(0, nt);
        chk("pend_go", 32'(state), 1);

`ifdef ROUND_PAUSE_EN
        set_sec(10, nt);
        chk("p_play", 32'(time_left), 23);
        pause = 1'b1; tick(2);
        chk("p_enable", 32'(cnt_enable), 0);
        chk("p_paused", 32'(paused), 1);
        chk("p_tl", 32'(time_left), 23);
        set_sec(11, nt);
        chk("p_frozen", 32'(time_left), 23);
        chk("p_state", 32'(state), 2);
        pause = 1'b0; tick(1);
        chk("p_release_en", 32'(cnt_enable), 1);
        chk("p_release_flag", 32'(paused), 0);
        chk("p_release_tl", 32'(time_left), 22);
`endif

        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_clear", 32'(cnt_clear), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
